derot_loop_ctrl: RTL and testbench
==================================

// Module: derot_loop_ctrl
// PURPOSE
//  Carrier-loop controller that sequences the RX derotator. Takes per-symbol phase error from
//  the phase detector, runs a 2nd-order PI loop with gain scheduling (ACQ/TRACK/LOCK) and a lock
//  detector, and drives the phase word into the DDS feeding the derotator's cos/sin inputs.
// PARAMETERS
//  ERR_WIDTH    16     signed phase-error width (Q1.ERR_WIDTH-1)
//  PHASE_WIDTH  32     DDS phase word width, full scale = 2*pi
//  KP_SH_ACQ    6      prop gain left shift (ACQ)
//  KI_SH_ACQ    2      integ gain left shift (ACQ)
//  KP_SH_TRK    3      prop gain left shift (TRACK/LOCK)
//  KI_SH_TRK    0      integ gain left shift (TRACK/LOCK)
//  FREQ_MAX     2**24  |integrator| saturation bound
//  ACQ_SYMS     256    symbols spent in ACQ before TRACK
//  LOCK_THR     1024   |err| below this counts as a hit
//  LOCK_CNT     64     consecutive hits TRACK->LOCK
//  UNLOCK_CNT   16     consecutive misses LOCK->TRACK
// PORTS
//  clk          in   1            system clock
//  rst_n        in   1            asynchronous active-low reset
//  enable       in   1            1 = loop runs; 0 = IDLE
//  sym_valid    in   1            err valid (symbol-centre strobe)
//  err          in   ERR_WIDTH    signed phase error
//  phase_out    out  PHASE_WIDTH  DDS phase word
//  freq_out     out  PHASE_WIDTH  signed integrator (freq word)
//  state_out    out  2            00 IDLE 01 ACQ 10 TRACK 11 LOCK
//  locked       out  1            1 in LOCK
// BEHAVIOUR
//  - rst_n low (async): phase_out=0, freq_out=0, state IDLE, locked=0, all counters 0.
//  - Every clk in ACQ/TRACK/LOCK: phase_out <= phase_out + freq_out + (sym_valid ? P : 0),
//    modulo 2**PHASE_WIDTH (free wrap, no saturation). P = sext(err)<<<KP_SH.
//  - On sym_valid: freq_out <= sat(freq_out + (sext(err)<<<KI_SH), +-FREQ_MAX). Shifts chosen
//    from state at that cycle. Latency: err in cycle N visible on phase_out/freq_out at N+1.
//  - |err| computed with saturation: -2**(ERR_WIDTH-1) maps to 2**(ERR_WIDTH-1)-1.
//  - FSM (advances only on sym_valid except enable):
//    IDLE : enable=1 -> ACQ (sym counter cleared).
//    ACQ  : count symbols; ACQ_SYMS-th symbol -> TRACK, hit counter cleared.
//    TRACK: hit -> hit_cnt++, miss -> hit_cnt=0; hit_cnt reaching LOCK_CNT -> LOCK, locked=1.
//    LOCK : miss -> miss_cnt++, hit -> miss_cnt=0; miss_cnt reaching UNLOCK_CNT -> TRACK,
//           locked=0, hit_cnt cleared.
//  - enable=0 in any state: next cycle IDLE, freq_out=0, counters cleared, locked=0,
//    phase_out holds value. enable=0 has priority over a coincident sym_valid (err dropped).
//  - IDLE ignores sym_valid. Re-enable restarts at ACQ from held phase.
//  - Counters saturate at their terminal counts; no wrap.
//  - rst_n asserted mid-operation: immediate return to reset values, no partial update.
// STRUCTURE
//  - derot_pkg: state_t enum (IDLE/ACQ/TRACK/LOCK), abs_sat() function, default gain constants.
//  - Sub-module derot_lock_det: |err| compare, hit/miss counters, lock/unlock pulses to FSM.
//  - Top: FSM, gain mux, PI integrator with saturation, phase accumulator.
// TESTING
//  - Reset: rst_n=0 mid-run -> phase_out=0, freq_out=0, state_out=00, locked=0 same cycle.
//  - err=0 always, enable=1 -> ACQ for 256 syms, TRACK, LOCK after 64 more; phase_out stays 0.
//  - err=+1 single strobe in TRACK -> freq_out=1 and phase_out=8 next cycle; phase_out +1/clk after.
//  - err=+32767 continuous in ACQ -> freq_out clamps at 2**24, phase_out wraps past 2**32 cleanly.
//  - In LOCK, 16 syms err=2000 -> TRACK, locked=0; 15 misses then 1 hit -> stays LOCK.
//  - enable drops with coincident sym_valid err=500 -> IDLE, freq_out=0, phase_out unchanged.

Source files
------------

// File: rtl/derot_pkg.sv
// Shared types and defaults for the derotator carrier-loop controller.
package derot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACQ   = 2'b01,
        TRACK = 2'b10,
        LOCK  = 2'b11
    } state_t;

    localparam int DEF_ERR_WIDTH   = 16;
    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_KP_SH_ACQ   = 6;
    localparam int DEF_KI_SH_ACQ   = 2;
    localparam int DEF_KP_SH_TRK   = 3;
    localparam int DEF_KI_SH_TRK   = 0;
    localparam int DEF_FREQ_MAX    = 2**24;
    localparam int DEF_ACQ_SYMS    = 256;
    localparam int DEF_LOCK_THR    = 1024;
    localparam int DEF_LOCK_CNT    = 64;
    localparam int DEF_UNLOCK_CNT  = 16;

    // |v| for a w-bit signed value; the most negative code folds onto the most positive.
    function automatic int abs_sat(input int v, input int w);
        int lim;
        lim = (1 <<< (w - 1)) - 1;
        if (v < -lim)
            return lim;
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/derot_lock_det.sv
// Lock detector: counts consecutive hits in TRACK and consecutive misses in LOCK,
// and flags the symbol on which the FSM must change state.
module derot_lock_det
    import derot_pkg::*;
#(
    parameter int ERR_WIDTH  = DEF_ERR_WIDTH,
    parameter int LOCK_THR   = DEF_LOCK_THR,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT = DEF_UNLOCK_CNT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        sym_ok,
    input  logic                        in_track,
    input  logic                        in_lock,
    input  logic signed [ERR_WIDTH-1:0] err,
    output logic                        lock_pulse,
    output logic                        unlock_pulse
);

    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);
    localparam logic [HW-1:0] HIT_LAST  = HW'(LOCK_CNT - 1);
    localparam logic [HW-1:0] HIT_TOP   = HW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_CNT - 1);

    logic [HW-1:0] hit_cnt_reg, hit_cnt_next;
    logic [MW-1:0] miss_cnt_reg, miss_cnt_next;
    logic          hit;

    assign hit = abs_sat(int'(err), ERR_WIDTH) < LOCK_THR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            hit_cnt_reg  <= hit_cnt_next;
            miss_cnt_reg <= miss_cnt_next;
        end
    end

    always_comb begin
        hit_cnt_next  = hit_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        lock_pulse    = 1'b0;
        unlock_pulse  = 1'b0;
        if (clear || !(in_track || in_lock)) begin
            hit_cnt_next  = '0;
            miss_cnt_next = '0;
        end else if (sym_ok && in_track) begin
            miss_cnt_next = '0;
            if (!hit) begin
                hit_cnt_next = '0;
            end else if (hit_cnt_reg == HIT_LAST) begin
                lock_pulse   = 1'b1;
                hit_cnt_next = HIT_TOP;
            end else if (hit_cnt_reg != HIT_TOP) begin
                hit_cnt_next = hit_cnt_reg + 1'b1;
            end
        end else if (sym_ok && in_lock) begin
            // hit_cnt stays parked at its terminal count while locked
            if (hit) begin
                miss_cnt_next = '0;
            end else if (miss_cnt_reg == MISS_LAST) begin
                unlock_pulse  = 1'b1;
                miss_cnt_next = '0;
                hit_cnt_next  = '0;
            end else begin
                miss_cnt_next = miss_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/derot_loop_ctrl.sv
// Carrier-loop controller: gain-scheduled 2nd-order PI loop driving the DDS phase word,
// sequenced IDLE -> ACQ -> TRACK <-> LOCK by symbol strobes and the lock detector.
module derot_loop_ctrl
    import derot_pkg::*;
#(
    parameter int ERR_WIDTH   = DEF_ERR_WIDTH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int KP_SH_ACQ   = DEF_KP_SH_ACQ,
    parameter int KI_SH_ACQ   = DEF_KI_SH_ACQ,
    parameter int KP_SH_TRK   = DEF_KP_SH_TRK,
    parameter int KI_SH_TRK   = DEF_KI_SH_TRK,
    parameter int FREQ_MAX    = DEF_FREQ_MAX,
    parameter int ACQ_SYMS    = DEF_ACQ_SYMS,
    parameter int LOCK_THR    = DEF_LOCK_THR,
    parameter int LOCK_CNT    = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT  = DEF_UNLOCK_CNT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          sym_valid,
    input  logic signed [ERR_WIDTH-1:0]   err,
    output logic        [PHASE_WIDTH-1:0] phase_out,
    output logic signed [PHASE_WIDTH-1:0] freq_out,
    output logic        [1:0]             state_out,
    output logic                          locked
);

    localparam int SW = $clog2(ACQ_SYMS + 1);
    localparam logic [SW-1:0] ACQ_LAST = SW'(ACQ_SYMS - 1);
    localparam logic signed [PHASE_WIDTH:0] FREQ_HI = (PHASE_WIDTH + 1)'(FREQ_MAX);
    localparam logic signed [PHASE_WIDTH:0] FREQ_LO = -FREQ_HI;

    state_t                         state_reg, state_next;
    logic [SW-1:0]                  sym_cnt_reg, sym_cnt_next;
    logic [PHASE_WIDTH-1:0]         phase_reg, phase_next;
    logic signed [PHASE_WIDTH-1:0]  freq_reg, freq_next;

    logic                           active, sym_ok, acq_gain;
    logic                           lock_pulse, unlock_pulse;
    logic signed [PHASE_WIDTH-1:0]  err_ext, p_term, i_term;
    logic signed [PHASE_WIDTH:0]    freq_sum;

    assign active   = (state_reg != IDLE);
    assign sym_ok   = sym_valid && enable && active;
    assign acq_gain = (state_reg == ACQ);

    derot_lock_det #(
        .ERR_WIDTH  (ERR_WIDTH),
        .LOCK_THR   (LOCK_THR),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_det (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (!enable),
        .sym_ok       (sym_ok),
        .in_track     (state_reg == TRACK),
        .in_lock      (state_reg == LOCK),
        .err          (err),
        .lock_pulse   (lock_pulse),
        .unlock_pulse (unlock_pulse)
    );

    // Gain mux: constant shifts on both branches, selected by the current state.
    assign err_ext  = PHASE_WIDTH'(err);
    assign p_term   = acq_gain ? (err_ext <<< KP_SH_ACQ) : (err_ext <<< KP_SH_TRK);
    assign i_term   = acq_gain ? (err_ext <<< KI_SH_ACQ) : (err_ext <<< KI_SH_TRK);
    assign freq_sum = {freq_reg[PHASE_WIDTH-1], freq_reg} + {i_term[PHASE_WIDTH-1], i_term};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sym_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            sym_cnt_reg <= sym_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sym_cnt_next = sym_cnt_reg;
        if (!enable) begin
            state_next   = IDLE;
            sym_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next   = ACQ;
                    sym_cnt_next = '0;
                end
                ACQ: begin
                    if (sym_ok) begin
                        if (sym_cnt_reg == ACQ_LAST) begin
                            state_next   = TRACK;
                            sym_cnt_next = '0;
                        end else begin
                            sym_cnt_next = sym_cnt_reg + 1'b1;
                        end
                    end
                end
                TRACK:   if (lock_pulse)   state_next = LOCK;
                LOCK:    if (unlock_pulse) state_next = TRACK;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        state_out = state_reg;
        locked    = (state_reg == LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
            freq_reg  <= '0;
        end else begin
            phase_reg <= phase_next;
            freq_reg  <= freq_next;
        end
    end

    // Disable clears the integrator but freezes the phase so a restart is phase-continuous.
    always_comb begin
        phase_next = phase_reg;
        freq_next  = freq_reg;
        if (!enable) begin
            freq_next = '0;
        end else if (active) begin
            phase_next = phase_reg + $unsigned(freq_reg)
                       + (sym_ok ? $unsigned(p_term) : '0);
            if (sym_ok) begin
                if (freq_sum > FREQ_HI)
                    freq_next = FREQ_HI[PHASE_WIDTH-1:0];
                else if (freq_sum < FREQ_LO)
                    freq_next = FREQ_LO[PHASE_WIDTH-1:0];
                else
                    freq_next = freq_sum[PHASE_WIDTH-1:0];
            end
        end
    end

    assign phase_out = phase_reg;
    assign freq_out  = freq_reg;

endmodule

// File: tb/tb_derot_loop_ctrl.sv
// Scoreboard bench for derot_loop_ctrl: a behavioural loop model queues the expected
// outputs for each driven cycle and each scenario task compares them on the next falling edge.
module tb_derot_loop_ctrl;

    localparam longint FMAX = 64'd16777216;

    typedef struct packed {
        logic [31:0] ph;
        logic [31:0] fr;
        logic [1:0]  st;
        logic        lk;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               sym_valid;
    logic signed [15:0] err;
    logic [31:0]        phase_out;
    logic [31:0]        freq_out;
    logic [1:0]         state_out;
    logic               locked;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    logic [31:0] m_phase;
    longint      m_freq;
    int          m_state, m_sym, m_hit, m_miss;

    derot_loop_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sym_valid (sym_valid),
        .err       (err),
        .phase_out (phase_out),
        .freq_out  (freq_out),
        .state_out (state_out),
        .locked    (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_phase = '0;
        m_freq  = 0;
        m_state = 0;
        m_sym   = 0;
        m_hit   = 0;
        m_miss  = 0;
    endfunction

    // Drive one cycle of stimulus and queue what the loop should show after the next edge.
    task automatic apply(input logic en, input logic sv, input int e);
        longint p, f;
        int     kp, ki, mag;
        bit     hit;
        exp_t   x;
        enable    = en;
        sym_valid = sv;
        err       = 16'(e);
        if (!en) begin
            m_state = 0; m_freq = 0; m_sym = 0; m_hit = 0; m_miss = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_sym = 0;
        end else begin
            kp  = (m_state == 1) ? 64 : 8;
            ki  = (m_state == 1) ? 4 : 1;
            p   = sv ? longint'(e) * kp : 0;
            m_phase = 32'(longint'(m_phase) + m_freq + p);
            if (sv) begin
                f = m_freq + longint'(e) * ki;
                if (f > FMAX)  f = FMAX;
                if (f < -FMAX) f = -FMAX;
                m_freq = f;
                mag = (e < 0) ? -e : e;
                hit = (mag < 1024);
                case (m_state)
                    1: begin
                        m_sym++;
                        if (m_sym == 256) begin m_state = 2; m_sym = 0; m_hit = 0; end
                    end
                    2: begin
                        if (hit) m_hit++; else m_hit = 0;
                        if (m_hit == 64) begin m_state = 3; m_miss = 0; end
                    end
                    default: begin
                        if (hit) m_miss = 0; else m_miss++;
                        if (m_miss == 16) begin m_state = 2; m_hit = 0; m_miss = 0; end
                    end
                endcase
            end
        end
        x.ph = m_phase;
        x.fr = 32'(m_freq);
        x.st = 2'(m_state);
        x.lk = (m_state == 3);
        sb.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; sym_valid = 1'b0; err = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t got;
        got = {phase_out, freq_out, state_out, locked};
        total++;
        if (got !== exp_t'(0)) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", got, exp_t'(0));
        end
        rst_n = 1'b1;
        $display("scenario reset: outputs checked while rst_n low");
    endtask

    task automatic test_acq_to_lock();
        exp_t got, want;
        do_reset();
        for (int c = 0; c < 646; c++) begin
            apply(1'b1, (c % 2) == 1, 0);
            @(negedge clk);
            want = sb.pop_front();
            got  = {phase_out, freq_out, state_out, locked};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL acq_to_lock cyc=%0d got=%h want=%h", c, got, want);
            end
        end
        total++;
        if (locked !== 1'b1 || state_out !== 2'b11 || phase_out !== 32'd0) begin
            bad++;
            $display("FAIL acq_to_lock_end got st=%b lk=%b ph=%h want st=11 lk=1 ph=0",
                     state_out, locked, phase_out);
        end
        $display("scenario acq_to_lock: 320 zero-error symbols");
    endtask

    task automatic test_single_strobe();
        exp_t got, want;
        do_reset();
        for (int c = 0; c < 268; c++) begin
            apply(1'b1, (c >= 1 && c <= 257), (c == 257) ? 1 : 0);
            @(negedge clk);
            want = sb.pop_front();
            got  = {phase_out, freq_out, state_out, locked};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL single_strobe cyc=%0d got=%h want=%h", c, got, want);
            end
            if (c == 257) begin
                total++;
                if (phase_out !== 32'd8 || freq_out !== 32'd1) begin
                    bad++;
                    $display("FAIL strobe_response got ph=%0d fr=%0d want ph=8 fr=1",
                             phase_out, freq_out);
                end
            end
        end
        total++;
        if (phase_out !== 32'd18) begin
            bad++;
            $display("FAIL strobe_ramp got ph=%0d want ph=18", phase_out);
        end
        $display("scenario single_strobe: err=+1 in TRACK");
    endtask

    task automatic test_saturation();
        exp_t        got, want;
        logic [31:0] prev;
        bit          wrapped;
        do_reset();
        wrapped = 1'b0;
        prev    = '0;
        for (int c = 0; c < 351; c++) begin
            apply(1'b1, (c >= 1 && c <= 250), 32767);
            @(negedge clk);
            want = sb.pop_front();
            got  = {phase_out, freq_out, state_out, locked};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sat_pos cyc=%0d got=%h want=%h", c, got, want);
            end
            if (phase_out < prev) wrapped = 1'b1;
            prev = phase_out;
        end
        total++;
        if (freq_out !== 32'h0100_0000 || !wrapped) begin
            bad++;
            $display("FAIL sat_pos_end got fr=%h wrapped=%b want fr=01000000 wrapped=1",
                     freq_out, wrapped);
        end
        do_reset();
        for (int c = 0; c < 131; c++) begin
            apply(1'b1, c >= 1, -32768);
            @(negedge clk);
            want = sb.pop_front();
            got  = {phase_out, freq_out, state_out, locked};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sat_neg cyc=%0d got=%h want=%h", c, got, want);
            end
        end
        total++;
        if (freq_out !== 32'hFF00_0000) begin
            bad++;
            $display("FAIL sat_neg_end got fr=%h want fr=ff000000", freq_out);
        end
        $display("scenario saturation: integrator clamps at +/-2**24, phase wraps");
    endtask

    task automatic test_unlock();
        exp_t got, want;
        int   q[$];
        int   idx_stay;
        do_reset();
        for (int i = 0; i < 256; i++) q.push_back(0);
        for (int i = 0; i < 30; i++)  q.push_back((i % 2) ? -1023 : 1023);
        q.push_back(1024);
        for (int i = 0; i < 64; i++)  q.push_back((i % 2) ? 1023 : -1023);
        for (int i = 0; i < 15; i++)  q.push_back(2000);
        idx_stay = q.size();
        q.push_back(0);
        for (int i = 0; i < 15; i++)  q.push_back(-2000);
        q.push_back(-1023);
        for (int i = 0; i < 16; i++)  q.push_back(-32768);
        for (int c = 0; c < q.size() + 4; c++) begin
            if (c == 0)
                apply(1'b1, 1'b0, 0);
            else if (c <= q.size())
                apply(1'b1, 1'b1, q[c-1]);
            else
                apply(1'b1, 1'b0, 0);
            @(negedge clk);
            want = sb.pop_front();
            got  = {phase_out, freq_out, state_out, locked};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL unlock cyc=%0d got=%h want=%h", c, got, want);
            end
            if (c == idx_stay + 1) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL stay_locked got lk=%b want lk=1", locked);
                end
            end
        end
        total++;
        if (state_out !== 2'b10 || locked !== 1'b0) begin
            bad++;
            $display("FAIL unlock_end got st=%b lk=%b want st=10 lk=0", state_out, locked);
        end
        $display("scenario unlock: 15 misses+hit holds LOCK, 16 misses drop to TRACK");
    endtask

    task automatic test_enable_drop();
        exp_t got, want;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            if (c < 21)       apply(1'b1, c >= 1, 300);
            else if (c == 21) apply(1'b0, 1'b1, 500);
            else if (c < 25)  apply(1'b0, c[0], 700);
            else              apply(1'b1, c >= 26, -200);
            @(negedge clk);
            want = sb.pop_front();
            got  = {phase_out, freq_out, state_out, locked};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL enable_drop cyc=%0d got=%h want=%h", c, got, want);
            end
            if (c == 21) begin
                total++;
                if (freq_out !== 32'd0 || state_out !== 2'b00) begin
                    bad++;
                    $display("FAIL drop_idle got fr=%h st=%b want fr=0 st=00", freq_out, state_out);
                end
            end
        end
        $display("scenario enable_drop: coincident strobe dropped, restart from held phase");
    endtask

    task automatic test_back_to_back();
        exp_t got, want;
        int   e, r;
        bit   en, sv, quiet;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            quiet = ((c / 200) % 2) == 0;
            en = ($urandom_range(0, 899) != 0);
            sv = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 99);
            if (r < (quiet ? 99 : 70))
                e = $urandom_range(0, 2046) - 1023;
            else if (r < 96)
                e = $urandom_range(1024, 1100) * (r[0] ? -1 : 1);
            else if (r < 99)
                e = $urandom_range(0, 65535) - 32768;
            else
                e = -32768;
            apply(en, sv, e);
            @(negedge clk);
            want = sb.pop_front();
            got  = {phase_out, freq_out, state_out, locked};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", c, got, want);
            end
        end
        $display("scenario back_to_back: 3000 random cycles");
    endtask

    task automatic test_reset_midrun();
        exp_t got, want;
        for (int c = 0; c < 30; c++) begin
            apply(1'b1, 1'b1, 50);
            @(negedge clk);
            want = sb.pop_front();
            got  = {phase_out, freq_out, state_out, locked};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL pre_reset cyc=%0d got=%h want=%h", c, got, want);
            end
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        got = {phase_out, freq_out, state_out, locked};
        total++;
        if (got !== exp_t'(0)) begin
            bad++;
            $display("FAIL reset_async got=%h want=%h", got, exp_t'(0));
        end
        @(negedge clk);
        got = {phase_out, freq_out, state_out, locked};
        total++;
        if (got !== exp_t'(0)) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", got, exp_t'(0));
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            apply(1'b1, c >= 1, 1000);
            @(negedge clk);
            want = sb.pop_front();
            got  = {phase_out, freq_out, state_out, locked};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", c, got, want);
            end
        end
        $display("scenario reset_midrun: asynchronous reset during operation");
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sym_valid = 1'b0; err = '0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_acq_to_lock();
        test_single_strobe();
        test_saturation();
        test_unlock();
        test_enable_drop();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
